// File: rtl/page_drain_ctrl.sv
// Page-completion controller: follows one page from first token to cleaner hand-off and raises
// page_finish once the token FIFO, parsers and RAM banks have stayed empty for a full drain window.
module page_drain_ctrl #(
  parameter int NUM_PARSER   = 6,
  parameter int NUM_RAM      = 16,
  parameter int DRAIN_CYCLES = 16,
  parameter int TIMEOUT_W    = 20
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_tf_empty,
  input  logic [NUM_PARSER-1:0] i_ps_empty,
  input  logic [NUM_RAM-1:0]    i_ram_empty,
  input  logic                  i_page_input_finish,
  input  logic                  i_cl_finish,
  output logic                  o_page_finish,
  output logic                  o_busy,
  output logic [15:0]           o_page_done_cnt,
  output logic                  o_timeout_err
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]        DRAIN_MAX = DW'(DRAIN_CYCLES);
  localparam logic [TIMEOUT_W-1:0] WD_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_all_empty;
  logic [DW-1:0]          r_drain_cnt;
  logic                   r_in_fin;
  logic [TIMEOUT_W-1:0]   r_wd_cnt;
  logic                   r_to_skip;
  logic                   r_page_finish;
  logic                   r_timeout_err;
  logic [15:0]            r_page_done_cnt;
  logic                   w_wd_expired;
  logic                   w_drain_done;
  logic                   w_to_fire;
  logic                   w_run_entry;

  assign w_wd_expired = (r_wd_cnt == WD_MAX);
  assign w_drain_done = (r_drain_cnt == DRAIN_MAX) & r_all_empty & i_tf_empty;
  assign w_run_entry  = (r_state == S_IDLE) & (w_state_nxt == S_RUN);

  always_comb begin
    w_state_nxt = r_state;
    w_to_fire   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_tf_empty || r_in_fin || i_page_input_finish) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (r_in_fin && i_tf_empty) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_wd_expired) begin
          w_state_nxt = S_DONE;
          w_to_fire   = 1'b1;
        end else if (w_drain_done) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // A cleaner hand-off in the same cycle as the watchdog still counts as a good page.
        if (i_cl_finish) begin
          w_state_nxt = S_DONE;
        end else if (w_wd_expired) begin
          w_state_nxt = S_DONE;
          w_to_fire   = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_all_empty     <= 1'b0;
      r_drain_cnt     <= '0;
      r_in_fin        <= 1'b0;
      r_wd_cnt        <= '0;
      r_to_skip       <= 1'b0;
      r_page_finish   <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_page_done_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_all_empty <= (&i_ps_empty) & (&i_ram_empty) & i_tf_empty;

      if (!r_all_empty)                 r_drain_cnt <= '0;
      else if (r_drain_cnt != DRAIN_MAX) r_drain_cnt <= r_drain_cnt + 1'b1;

      // Set wins over the DONE clear so a pulse landing in DONE carries into the next page.
      r_in_fin <= i_page_input_finish | (r_in_fin & (r_state != S_DONE));

      if (w_run_entry)
        r_wd_cnt <= '0;
      else if (((r_state == S_DRAIN) || (r_state == S_FLUSH)) && !w_wd_expired)
        r_wd_cnt <= r_wd_cnt + 1'b1;

      if (w_to_fire)               r_to_skip <= 1'b1;
      else if (r_state == S_DONE)  r_to_skip <= 1'b0;

      r_page_finish <= (w_state_nxt == S_FLUSH);

      if (w_to_fire) r_timeout_err <= 1'b1;

      if ((r_state == S_DONE) && !r_to_skip) r_page_done_cnt <= r_page_done_cnt + 16'd1;
    end
  end

  assign o_page_finish   = r_page_finish;
  assign o_busy          = (r_state != S_IDLE);
  assign o_page_done_cnt = r_page_done_cnt;
  assign o_timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_page_drain_ctrl.sv
// Bench for page_drain_ctrl: directed page scenarios with literal expectations, then randomized
// traffic, all compared every cycle against a page-level behavioural model.
module tb_page_drain_ctrl;

  localparam int NP = 6;
  localparam int NR = 16;
  localparam int DC = 16;
  localparam int TW = 8;
  localparam int WD_LIMIT = (1 << TW) - 1;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_FLUSH = 3;
  localparam int P_DONE  = 4;

  localparam logic [NP-1:0] PS_ALL  = '1;
  localparam logic [NR-1:0] RAM_ALL = '1;
  localparam logic [NP-1:0] PS_HOLD = {{(NP-1){1'b1}}, 1'b0};

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          tfEmpty = 1'b1;
  logic [NP-1:0] psEmpty = '1;
  logic [NR-1:0] ramEmpty = '1;
  logic          pif = 1'b0;
  logic          clFinish = 1'b0;
  logic          pageFinish;
  logic          busy;
  logic [15:0]   pageDoneCnt;
  logic          timeoutErr;

  int checks = 0;
  int failures = 0;

  page_drain_ctrl #(
    .NUM_PARSER(NP), .NUM_RAM(NR), .DRAIN_CYCLES(DC), .TIMEOUT_W(TW)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rstN),
    .i_tf_empty(tfEmpty),
    .i_ps_empty(psEmpty),
    .i_ram_empty(ramEmpty),
    .i_page_input_finish(pif),
    .i_cl_finish(clFinish),
    .o_page_finish(pageFinish),
    .o_busy(busy),
    .o_page_done_cnt(pageDoneCnt),
    .o_timeout_err(timeoutErr)
  );

  always #5 clk = ~clk;

  // Page-level model: the drain window is judged from a history of raw all-empty samples.
  int  mPhase = P_IDLE;
  bit  mInFin = 1'b0;
  int  mWatch = 0;
  bit  mTimedOut = 1'b0;
  bit  mErr = 1'b0;
  int  mPages = 0;
  bit  hist[$];

  function automatic bit windowFull();
    if (hist.size() < DC + 1) return 1'b0;
    foreach (hist[i]) if (!hist[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mPhase = P_IDLE; mInFin = 0; mWatch = 0; mTimedOut = 0; mErr = 0; mPages = 0;
      hist.delete();
    end else begin
      bit raw, expired, newInFin;
      raw      = tfEmpty && (&psEmpty) && (&ramEmpty);
      expired  = (mWatch == WD_LIMIT);
      newInFin = pif || (mInFin && mPhase != P_DONE);
      case (mPhase)
        P_IDLE:  if (!tfEmpty || mInFin || pif) begin mPhase = P_RUN; mWatch = 0; end
        P_RUN:   if (mInFin && tfEmpty) mPhase = P_DRAIN;
        P_DRAIN: begin
          if (expired) begin mPhase = P_DONE; mErr = 1; mTimedOut = 1; end
          else begin
            mWatch++;
            if (windowFull() && tfEmpty) mPhase = P_FLUSH;
          end
        end
        P_FLUSH: begin
          if (clFinish) mPhase = P_DONE;
          else if (expired) begin mPhase = P_DONE; mErr = 1; mTimedOut = 1; end
          else mWatch++;
        end
        default: begin
          if (!mTimedOut) mPages = (mPages + 1) % 65536;
          mTimedOut = 0;
          mPhase = P_IDLE;
        end
      endcase
      mInFin = newInFin;
      hist.push_back(raw);
      if (hist.size() > DC + 1) void'(hist.pop_front());
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_page_finish", 16'(pageFinish), 16'(mPhase == P_FLUSH));
    checkOutput("model_busy", 16'(busy), 16'(mPhase != P_IDLE));
    checkOutput("model_page_done_cnt", pageDoneCnt, 16'(mPages));
    checkOutput("model_timeout_err", 16'(timeoutErr), 16'(mErr));
  end

  task automatic applyStimulus(input logic tf, input logic [NP-1:0] ps, input logic [NR-1:0] ram,
                               input logic pifIn, input logic clIn);
    tfEmpty = tf; psEmpty = ps; ramEmpty = ram; pif = pifIn; clFinish = clIn;
    @(posedge clk);
    #1;
  endtask

  // Leaves the FSM in DRAIN with one parser still busy.
  task automatic startPage(input logic strayCl);
    applyStimulus(1'b0, PS_HOLD, RAM_ALL, 1'b0, 1'b0);
    applyStimulus(1'b1, PS_HOLD, RAM_ALL, 1'b1, strayCl);
    applyStimulus(1'b1, PS_HOLD, RAM_ALL, 1'b0, 1'b0);
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) applyStimulus(1'b1, PS_ALL, RAM_ALL, 1'b0, 1'b0);
    checkOutput("reset_page_finish", 16'(pageFinish), 16'd0);
    checkOutput("reset_busy", 16'(busy), 16'd0);
    checkOutput("reset_cnt", pageDoneCnt, 16'd0);
    checkOutput("reset_err", 16'(timeoutErr), 16'd0);
    rstN = 1'b1;

    // Normal page with window latency measured from the edge the inputs go empty
    startPage(1'b0);
    repeat (3) applyStimulus(1'b1, PS_HOLD, RAM_ALL, 1'b0, 1'b0);
    checkOutput("drain_busy", 16'(busy), 16'd1);
    for (int k = 1; k <= 18; k++) begin
      applyStimulus(1'b1, PS_ALL, RAM_ALL, 1'b0, 1'b0);
      if (k == 17) checkOutput("pf_edge17", 16'(pageFinish), 16'd0);
      if (k == 18) checkOutput("pf_edge18", 16'(pageFinish), 16'd1);
    end
    applyStimulus(1'b1, PS_HOLD, RAM_ALL, 1'b0, 1'b1);
    checkOutput("pf_after_cl", 16'(pageFinish), 16'd0);
    applyStimulus(1'b1, PS_ALL, RAM_ALL, 1'b0, 1'b0);
    checkOutput("cnt_page1", pageDoneCnt, 16'd1);
    checkOutput("idle_after_page1", 16'(busy), 16'd0);

    // Drain restart by a one-cycle parser glitch, plus stray cl_finish in RUN and DRAIN
    startPage(1'b1);
    for (int k = 1; k <= 29; k++) begin
      applyStimulus(1'b1, (k == 11) ? PS_ALL & ~(NP'(1) << 3) : PS_ALL, RAM_ALL, 1'b0, k == 6);
      if (k == 7)  checkOutput("stray_cl_cnt", pageDoneCnt, 16'd1);
      if (k == 28) checkOutput("pf_restart_28", 16'(pageFinish), 16'd0);
      if (k == 29) checkOutput("pf_restart_29", 16'(pageFinish), 16'd1);
    end

    // page_input_finish during DONE carries into the next page
    applyStimulus(1'b1, PS_ALL, RAM_ALL, 1'b0, 1'b1);
    applyStimulus(1'b1, PS_ALL, RAM_ALL, 1'b1, 1'b0);
    checkOutput("cnt_page2", pageDoneCnt, 16'd2);
    checkOutput("idle_after_page2", 16'(busy), 16'd0);
    applyStimulus(1'b1, PS_ALL, RAM_ALL, 1'b0, 1'b0);
    checkOutput("carry_run", 16'(busy), 16'd1);
    applyStimulus(1'b1, PS_ALL, RAM_ALL, 1'b0, 1'b0);
    checkOutput("carry_drain_pf", 16'(pageFinish), 16'd0);
    applyStimulus(1'b1, PS_ALL, RAM_ALL, 1'b0, 1'b0);
    checkOutput("carry_flush_pf", 16'(pageFinish), 16'd1);
    applyStimulus(1'b1, PS_ALL, RAM_ALL, 1'b0, 1'b1);
    applyStimulus(1'b1, PS_ALL, RAM_ALL, 1'b0, 1'b0);
    checkOutput("cnt_page3", pageDoneCnt, 16'd3);

    // Watchdog: DRAIN never completes
    startPage(1'b0);
    for (int k = 1; k <= 258; k++) begin
      applyStimulus(1'b1, PS_HOLD, RAM_ALL, 1'b0, 1'b0);
      if (k == 255) checkOutput("wd_err_255", 16'(timeoutErr), 16'd0);
      if (k == 256) checkOutput("wd_err_256", 16'(timeoutErr), 16'd1);
    end
    checkOutput("wd_pf", 16'(pageFinish), 16'd0);
    checkOutput("wd_idle", 16'(busy), 16'd0);
    checkOutput("wd_cnt_kept", pageDoneCnt, 16'd3);

    // Asynchronous reset in the middle of FLUSH
    startPage(1'b0);
    repeat (18) applyStimulus(1'b1, PS_ALL, RAM_ALL, 1'b0, 1'b0);
    checkOutput("flush_before_reset", 16'(pageFinish), 16'd1);
    @(posedge clk);
    #3 rstN = 1'b0;
    #1;
    checkOutput("async_pf", 16'(pageFinish), 16'd0);
    checkOutput("async_busy", 16'(busy), 16'd0);
    checkOutput("async_cnt", pageDoneCnt, 16'd0);
    checkOutput("async_err", 16'(timeoutErr), 16'd0);
    #10 rstN = 1'b1;

    // Randomized traffic in busy/quiet bursts, with occasional resets
    for (int ep = 0; ep < 300; ep++) begin
      int mode, len;
      mode = $urandom_range(0, 2);
      len  = $urandom_range(3, 40);
      if ($urandom_range(0, 39) == 0) begin
        applyStimulus(1'b1, PS_ALL, RAM_ALL, 1'b0, 1'b0);
        rstN = 1'b0;
        applyStimulus(1'b1, PS_ALL, RAM_ALL, 1'b0, 1'b0);
        rstN = 1'b1;
      end
      for (int c = 0; c < len; c++) begin
        logic tf;
        logic [NP-1:0] ps;
        logic [NR-1:0] ram;
        if (mode == 0) begin
          tf  = 1'($urandom_range(0, 1));
          ps  = ($urandom_range(0, 2) == 0) ? NP'($urandom) : PS_ALL;
          ram = ($urandom_range(0, 2) == 0) ? NR'($urandom) | NR'($urandom) : RAM_ALL;
        end else begin
          tf = 1'b1; ps = PS_ALL; ram = RAM_ALL;
        end
        applyStimulus(tf, ps, ram, $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0);
      end
    end

    applyStimulus(1'b1, PS_ALL, RAM_ALL, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
